// File: rtl/vm_pkg.sv
// ---------------------------------------------------------------------------
// vm_pkg: shared definitions for the multi-channel vending machine.
//   state_t        controller state encoding (IDLE, LOAD, CALC, OUT)
//   N_COIN         number of change denominations
//   DENOM          denominations, largest first (greedy change order)
//   is_legal_coin  true when a coin value matches one of DENOM
// ---------------------------------------------------------------------------
package vm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CALC = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    localparam int N_COIN = 5;
    localparam int DENOM [N_COIN] = '{50, 20, 10, 5, 1};

    function automatic logic is_legal_coin(input logic [5:0] coin);
        logic legal;
        legal = 1'b0;
        for (int i = 0; i < N_COIN; i++)
            if ({26'd0, coin} == DENOM[i]) legal = 1'b1;
        return legal;
    endfunction

endpackage

// File: rtl/vm_change_calc.sv
// ---------------------------------------------------------------------------
// vm_change_calc: one greedy change step.
//   remain       in   BAL_W   amount still to be paid out
//   idx          in   IDX_W   denomination index into DENOM
//   count        out  CONS_W  coins of DENOM[idx] to pay
//   next_remain  out  BAL_W   amount left after paying those coins
// Each branch divides by a constant, so no general divider is built; idx only
// selects which constant-divider result is forwarded.
// ---------------------------------------------------------------------------
module vm_change_calc
    import vm_pkg::*;
#(
    parameter int BAL_W  = 9,
    parameter int CONS_W = 4,
    parameter int IDX_W  = 3
) (
    input  logic [BAL_W-1:0]  remain,
    input  logic [IDX_W-1:0]  idx,
    output logic [CONS_W-1:0] count,
    output logic [BAL_W-1:0]  next_remain
);

    always_comb begin
        count       = '0;
        next_remain = remain;
        for (int i = 0; i < N_COIN; i++) begin
            if (idx == IDX_W'(i)) begin
                count       = CONS_W'(remain / BAL_W'(DENOM[i]));
                next_remain = remain % BAL_W'(DENOM[i]);
            end
        end
    end

endmodule

// File: rtl/vm_multi_channel.sv
// ---------------------------------------------------------------------------
// vm_multi_channel: parametrised vending-machine controller.
// Programs item prices, accumulates coins, serves buy / return requests,
// pays change greedily over vm_pkg::DENOM and streams a result frame.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   in_item_valid   price-load beat;  in_item_price / in_item_stock its data
//   in_coin_valid   coin strobe;      in_coin its value
//   in_buy_item     buy request item code (0 = none)
//   in_rtn_coin     return-coins request
//   out_monitor     current balance
//   out_consumer    frame data: item code, then coin counts largest first
//   out_sell_num    frame data: sold count of item k+1 on beat k
//   out_valid       frame beat valid
//
// Optional feature: define VM_STOCK_EN for per-item stock tracking.
// ---------------------------------------------------------------------------
module vm_multi_channel
    import vm_pkg::*;
#(
    parameter int N_ITEMS = 6,
    parameter int PRICE_W = 5,
    parameter int BAL_W   = 9,
    parameter int CNT_W   = 6,
    parameter int CONS_W  = 4,
    parameter int STOCK_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_item_valid,
    input  logic [PRICE_W-1:0] in_item_price,
    input  logic [STOCK_W-1:0] in_item_stock,
    input  logic               in_coin_valid,
    input  logic [5:0]         in_coin,
    input  logic [2:0]         in_buy_item,
    input  logic               in_rtn_coin,
    output logic [BAL_W-1:0]   out_monitor,
    output logic [CONS_W-1:0]  out_consumer,
    output logic [CNT_W-1:0]   out_sell_num,
    output logic               out_valid
);

    localparam int FRAME_LEN = (N_ITEMS > N_COIN + 1) ? N_ITEMS : N_COIN + 1;
    localparam int STEP_W    = $clog2(FRAME_LEN + 1);
    localparam logic [STEP_W-1:0] LAST_LOAD = STEP_W'(N_ITEMS - 1);
    localparam logic [STEP_W-1:0] LAST_CALC = STEP_W'(N_COIN - 1);
    localparam logic [STEP_W-1:0] FRAME_END = STEP_W'(FRAME_LEN);
    localparam logic [2:0]        MAX_CODE  = 3'(N_ITEMS);

    state_t             state;
    logic [BAL_W-1:0]   balance;
    logic [BAL_W-1:0]   remain;
    // One counter serves as load beat index, calc denomination index and
    // output beat index; the states never overlap.
    logic [STEP_W-1:0]  step;
    logic [STEP_W-1:0]  step_m1;
    logic [2:0]         code;
    logic [PRICE_W-1:0] price    [N_ITEMS];
    logic [CNT_W-1:0]   sold     [N_ITEMS];
    logic [CONS_W-1:0]  coin_cnt [N_COIN];

    logic [2:0]         buy_idx;
    logic               buy_legal;
    logic               buy_ok;
    logic [BAL_W-1:0]   item_price;
    logic [BAL_W:0]     coin_sum;
    logic [CONS_W-1:0]  calc_count;
    logic [BAL_W-1:0]   calc_next;
    logic [CONS_W-1:0]  beat_cons;
    logic [CNT_W-1:0]   beat_sell;

    assign buy_idx    = in_buy_item - 3'd1;
    assign buy_legal  = (in_buy_item != 3'd0) && (in_buy_item <= MAX_CODE);
    assign item_price = BAL_W'(price[buy_idx]);
    assign coin_sum   = {1'b0, balance} + (BAL_W+1)'(in_coin);
    assign step_m1    = step - STEP_W'(1);
    assign out_monitor = balance;

`ifdef VM_STOCK_EN
    logic [STOCK_W-1:0] stock [N_ITEMS];
    assign buy_ok = (balance >= item_price) && (stock[buy_idx] != '0);
`else
    logic unused_stock;
    assign unused_stock = ^in_item_stock;
    assign buy_ok = balance >= item_price;
`endif

    vm_change_calc #(
        .BAL_W (BAL_W),
        .CONS_W(CONS_W),
        .IDX_W (STEP_W)
    ) u_calc (
        .remain     (remain),
        .idx        (step),
        .count      (calc_count),
        .next_remain(calc_next)
    );

    // Frame beat contents: code, then coin counts, then zeros; sold counts
    // run alongside for the first N_ITEMS beats.
    always_comb begin
        beat_cons = '0;
        beat_sell = '0;
        if (step == '0)
            beat_cons = CONS_W'(code);
        else if (step <= STEP_W'(N_COIN))
            beat_cons = coin_cnt[step_m1];
        if (step < STEP_W'(N_ITEMS))
            beat_sell = sold[step];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            balance      <= '0;
            remain       <= '0;
            step         <= '0;
            code         <= '0;
            out_valid    <= 1'b0;
            out_consumer <= '0;
            out_sell_num <= '0;
            for (int i = 0; i < N_ITEMS; i++) begin
                price[i] <= '0;
                sold[i]  <= '0;
`ifdef VM_STOCK_EN
                stock[i] <= '0;
`endif
            end
            for (int i = 0; i < N_COIN; i++) coin_cnt[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_item_valid) begin
                        // The beat seen in IDLE is load beat 0.
                        price[0] <= in_item_price;
`ifdef VM_STOCK_EN
                        stock[0] <= in_item_stock;
`endif
                        for (int i = 0; i < N_ITEMS; i++) sold[i] <= '0;
                        balance <= '0;
                        step    <= STEP_W'(1);
                        state   <= (N_ITEMS > 1) ? ST_LOAD : ST_IDLE;
                    end else if (in_buy_item != 3'd0) begin
                        // Out-of-range codes are dropped along with any
                        // lower-priority request in the same cycle.
                        if (buy_legal) begin
                            step  <= '0;
                            state <= ST_CALC;
                            if (buy_ok) begin
                                remain  <= balance - item_price;
                                balance <= '0;
                                code    <= in_buy_item;
                                if (sold[buy_idx] != '1)
                                    sold[buy_idx] <= sold[buy_idx] + 1'b1;
`ifdef VM_STOCK_EN
                                stock[buy_idx] <= stock[buy_idx] - 1'b1;
`endif
                            end else begin
                                remain <= '0;
                                code   <= 3'd0;
                            end
                        end
                    end else if (in_rtn_coin) begin
                        remain  <= balance;
                        balance <= '0;
                        code    <= 3'd0;
                        step    <= '0;
                        state   <= ST_CALC;
                    end else if (in_coin_valid && is_legal_coin(in_coin)) begin
                        balance <= coin_sum[BAL_W] ? '1 : coin_sum[BAL_W-1:0];
                    end
                end

                ST_LOAD: begin
                    if (in_item_valid) begin
                        price[step] <= in_item_price;
`ifdef VM_STOCK_EN
                        stock[step] <= in_item_stock;
`endif
                        step <= step + 1'b1;
                        if (step == LAST_LOAD) state <= ST_IDLE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                ST_CALC: begin
                    coin_cnt[step] <= calc_count;
                    remain         <= calc_next;
                    if (step == LAST_CALC) begin
                        step  <= '0;
                        state <= ST_OUT;
                    end else begin
                        step <= step + 1'b1;
                    end
                end

                ST_OUT: begin
                    // Outputs are registered, so the final step only clears
                    // them; beat k is visible the cycle after step == k.
                    if (step == FRAME_END) begin
                        out_valid    <= 1'b0;
                        out_consumer <= '0;
                        out_sell_num <= '0;
                        step         <= '0;
                        state        <= ST_IDLE;
                    end else begin
                        out_valid    <= 1'b1;
                        out_consumer <= beat_cons;
                        out_sell_num <= beat_sell;
                        step         <= step + 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vm_multi_channel.sv
// ---------------------------------------------------------------------------
// tb_vm_multi_channel: self-checking bench for vm_multi_channel.
// A behavioural model (integer balance, price/sold tables, greedy change by
// division) predicts out_monitor and every frame beat; a compare process
// checks all outputs each cycle. Directed scenarios pin literal frames, then
// a randomized phase exercises mixed traffic.
// ---------------------------------------------------------------------------
module tb_vm_multi_channel;

    localparam int NI = 6;
    localparam int NC = 5;
    localparam int L  = 6;
    localparam int BAL_MAX  = 511;
    localparam int SOLD_MAX = 63;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_item_valid;
    logic [4:0] in_item_price;
    logic [3:0] in_item_stock;
    logic       in_coin_valid;
    logic [5:0] in_coin;
    logic [2:0] in_buy_item;
    logic       in_rtn_coin;
    logic [8:0] out_monitor;
    logic [3:0] out_consumer;
    logic [5:0] out_sell_num;
    logic       out_valid;

    vm_multi_channel dut (
        .clk          (clk),
        .rst          (rst),
        .in_item_valid(in_item_valid),
        .in_item_price(in_item_price),
        .in_item_stock(in_item_stock),
        .in_coin_valid(in_coin_valid),
        .in_coin      (in_coin),
        .in_buy_item  (in_buy_item),
        .in_rtn_coin  (in_rtn_coin),
        .out_monitor  (out_monitor),
        .out_consumer (out_consumer),
        .out_sell_num (out_sell_num),
        .out_valid    (out_valid)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int den_tab [NC] = '{50, 20, 10, 5, 1};
    int m_bal = 0;
    int m_price [1:NI];
    int m_sold  [1:NI];
    int m_stock [1:NI];
    int cyc = 0;
    int f_start = -100;   // edge after which beat 0 is visible
    int ld_k = 0;
    bit loading = 0;
    int e_cons [L];
    int e_sell [L];

    function automatic bit legal(input int c);
        bit ok = 0;
        for (int i = 0; i < NC; i++) if (c == den_tab[i]) ok = 1;
        return ok;
    endfunction

    task automatic start_frame(input int c, input int amount);
        int r;
        r = amount;
        e_cons[0] = c;
        for (int i = 0; i < NC; i++) begin
            e_cons[i+1] = r / den_tab[i];
            r = r % den_tab[i];
        end
        for (int k = 0; k < L; k++) e_sell[k] = (k < NI) ? m_sold[k+1] : 0;
        f_start = cyc + 1 + NC;
    endtask

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_bal = 0;
            for (int i = 1; i <= NI; i++) begin m_price[i] = 0; m_sold[i] = 0; m_stock[i] = 0; end
            loading = 0;
            f_start = -100;
        end else begin
            cyc++;
            if (cyc <= f_start + L) begin
                // request in flight: every input ignored
            end else if (loading) begin
                if (in_item_valid) begin
                    m_price[ld_k] = in_item_price;
                    m_stock[ld_k] = in_item_stock;
                    ld_k++;
                    if (ld_k > NI) loading = 0;
                end else loading = 0;
            end else if (in_item_valid) begin
                m_price[1] = in_item_price;
                m_stock[1] = in_item_stock;
                for (int i = 1; i <= NI; i++) m_sold[i] = 0;
                m_bal = 0;
                ld_k = 2;
                loading = 1;
            end else if (in_buy_item != 0) begin
                if (in_buy_item <= NI) begin
                    int c;
                    bit ok;
                    c = in_buy_item;
                    ok = m_bal >= m_price[c];
`ifdef VM_STOCK_EN
                    ok = ok && (m_stock[c] > 0);
`endif
                    if (ok) begin
                        int rem;
                        rem = m_bal - m_price[c];
                        m_bal = 0;
                        if (m_sold[c] < SOLD_MAX) m_sold[c]++;
                        m_stock[c]--;
                        start_frame(c, rem);
                    end else start_frame(0, 0);
                end
            end else if (in_rtn_coin) begin
                start_frame(0, m_bal);
                m_bal = 0;
            end else if (in_coin_valid && legal(int'(in_coin))) begin
                m_bal = (m_bal + in_coin > BAL_MAX) ? BAL_MAX : m_bal + in_coin;
            end
        end
    end

    // ---------------- compare process ----------------
    int cap_n = 0;
    int cap_cons [8];
    int cap_sell [8];

    initial forever begin
        int beat;
        bit ev;
        @(posedge clk);
        #3;
        beat = cyc - f_start;
        ev = (beat >= 0) && (beat < L) && !rst;
        chk("valid",    out_valid,    ev);
        chk("consumer", out_consumer, ev ? e_cons[beat] : 0);
        chk("sell_num", out_sell_num, ev ? e_sell[beat] : 0);
        chk("monitor",  out_monitor,  m_bal);
        if (out_valid && cap_n < 8) begin
            cap_cons[cap_n] = out_consumer;
            cap_sell[cap_n] = out_sell_num;
            cap_n++;
        end
    end

    // ---------------- driver ----------------
    int base_price [NI] = '{10, 15, 20, 25, 30, 31};
    int exp_c [L];
    int exp_s [L];

    task automatic clear_in();
        in_item_valid = 0; in_item_price = 0; in_item_stock = 0;
        in_coin_valid = 0; in_coin = 0; in_buy_item = 0; in_rtn_coin = 0;
    endtask

    task automatic load_prices();
        for (int k = 0; k < NI; k++) begin
            in_item_valid = 1;
            in_item_price = 5'(base_price[k]);
            in_item_stock = 4'd1;
            @(negedge clk);
        end
        clear_in();
        @(negedge clk);
    endtask

    task automatic put_coin(input int v);
        in_coin_valid = 1;
        in_coin = 6'(v);
        @(negedge clk);
        clear_in();
    endtask

    task automatic request(input int c, input bit rtn);
        cap_n = 0;
        in_buy_item = 3'(c);
        in_rtn_coin = rtn;
        @(negedge clk);
        clear_in();
    endtask

    task automatic wait_beats(input int beats);
        int n = 0;
        while (cap_n < beats && n < 40) begin @(negedge clk); n++; end
        if (cap_n < beats) chk("frame_timeout", cap_n, beats);
    endtask

    task automatic finish_frame();
        wait_beats(L);
        @(negedge clk);   // last beat's cycle still ignores inputs
    endtask

    task automatic chk_frame(input string name);
        for (int k = 0; k < L; k++) begin
            chk($sformatf("%s_cons%0d", name, k), cap_cons[k], exp_c[k]);
            chk($sformatf("%s_sell%0d", name, k), cap_sell[k], exp_s[k]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        clear_in();
        repeat (3) @(negedge clk);
        chk("reset_valid",    out_valid,    0);
        chk("reset_consumer", out_consumer, 0);
        chk("reset_sell",     out_sell_num, 0);
        chk("reset_monitor",  out_monitor,  0);
        rst = 0;
        @(negedge clk);
        load_prices();

        // 1: 50+20, buy item 3 (price 20) -> change one 50
        put_coin(50); put_coin(20);
        chk("s1_monitor", out_monitor, 70);
        chk("s1_model_bal", m_bal, 70);
        request(3, 0); finish_frame();
        exp_c = '{3, 1, 0, 0, 0, 0}; exp_s = '{0, 0, 1, 0, 0, 0};
        chk_frame("s1");
        chk("s1_monitor_after", out_monitor, 0);
        chk("s1_model_sold3", m_sold[3], 1);

        // 2: insufficient balance for item 6
        put_coin(10);
        request(6, 0); finish_frame();
        exp_c = '{0, 0, 0, 0, 0, 0}; exp_s = '{0, 0, 1, 0, 0, 0};
        chk_frame("s2");
        chk("s2_monitor", out_monitor, 10);

        // empty the 10 left over, then 3: 57 returned
        request(0, 1); finish_frame();
        exp_c = '{0, 0, 0, 1, 0, 0};
        chk_frame("s3a");
        put_coin(50); put_coin(5); put_coin(1); put_coin(1);
        chk("s3_monitor", out_monitor, 57);
        request(0, 1); finish_frame();
        exp_c = '{0, 1, 0, 0, 1, 2};
        chk_frame("s3");

        // 4: saturation at 511
        for (int i = 0; i < 11; i++) put_coin(50);
        chk("s4_monitor", out_monitor, 511);
        chk("s4_model_bal", m_bal, 511);
        request(0, 1); finish_frame();
        exp_c = '{0, 10, 0, 1, 0, 1};
        chk_frame("s4");

        // 5: buy beats rtn; coin during OUT ignored
        put_coin(20);
        request(1, 1);
        wait_beats(1);
        put_coin(50);
        finish_frame();
        exp_c = '{1, 0, 0, 1, 0, 0}; exp_s = '{1, 0, 1, 0, 0, 0};
        chk_frame("s5");
        chk("s5_monitor", out_monitor, 0);

        // 6: reset mid-frame
        put_coin(20);
        request(2, 0);
        wait_beats(3);
        rst = 1;
        #1;
        chk("s6_valid",    out_valid,    0);
        chk("s6_consumer", out_consumer, 0);
        chk("s6_sell",     out_sell_num, 0);
        chk("s6_monitor",  out_monitor,  0);
        @(negedge clk); @(negedge clk);
        rst = 0;
        @(negedge clk);
        request(0, 1); finish_frame();
        exp_c = '{0, 0, 0, 0, 0, 0}; exp_s = '{0, 0, 0, 0, 0, 0};
        chk_frame("s6");

        // randomized traffic against the model
        load_prices();
        for (int n = 0; n < 800; n++) begin
            in_item_valid = ($urandom_range(0, 99) < 2) ||
                            (in_item_valid && $urandom_range(0, 3) != 0);
            in_item_price = 5'($urandom_range(0, 31));
            in_item_stock = 4'($urandom_range(0, 3));
            in_coin_valid = ($urandom_range(0, 1) == 1);
            in_coin = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                                  : 6'(den_tab[$urandom_range(0, NC-1)]);
            in_buy_item = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            in_rtn_coin = ($urandom_range(0, 24) == 0);
            @(negedge clk);
        end
        clear_in();
        repeat (30) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
